proc_instr_sequencer: RTL

PROC_INSTR_SEQUENCER -- requirements
Module: proc_instr_sequencer

---
 rtl/proc_instr_sequencer_pkg.sv | 30 +++
 rtl/proc_instr_sequencer_prog_mem.sv | 25 ++
 rtl/proc_instr_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/proc_instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states,
// program-entry field widths.
package proc_instr_sequencer_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND  = 3'b010;
  localparam logic [OPC_W-1:0] OP_OR   = 3'b011;
  localparam logic [OPC_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OPC_W-1:0] OP_SHL  = 3'b101;
  localparam logic [OPC_W-1:0] OP_SHR  = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT_HALT,
    S_DONE,
    S_ERR
  } state_e;

  // Entry layout is {opcode, addr, operand_a, operand_b}.
  function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
    return OPC_W + aw + 2 * dw;
  endfunction

endpackage

// File: rtl/proc_instr_sequencer_prog_mem.sv
// Program store: DEPTH x WIDTH register file, one write port, one async read port.
// Contents are deliberately not reset.
module proc_prog_mem #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_instr_sequencer.sv
// Steps through a small program, handing each entry to a processor over a
// ready/execute handshake and collecting results until HALT or the last entry.
module proc_instr_sequencer
  import proc_instr_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned IDX_W   = $clog2(PROG_DEPTH),
  localparam int unsigned ENTRY_W = entry_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [IDX_W-1:0]      prog_waddr,
  input  logic [ENTRY_W-1:0]    prog_wdata,
  input  logic                  start,
  output logic [OPC_W-1:0]      proc_opcode,
  output logic [ADDR_WIDTH-1:0] proc_addr,
  output logic [DATA_WIDTH-1:0] proc_operand_a,
  output logic [DATA_WIDTH-1:0] proc_operand_b,
  output logic                  proc_execute,
  input  logic                  proc_ready,
  input  logic                  proc_halt,
  input  logic [DATA_WIDTH-1:0] proc_result,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] last_result,
  output logic [IDX_W-1:0]      step_idx
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  pending, pending_n;
  logic [IDX_W-1:0]      step_n, raddr;
  logic [OPC_W-1:0]      opc_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] a_n, b_n, last_n;
  logic                  exec_n, busy_n, done_n, terr_n, rv_n;
  logic                  prog_open, mem_we, reload, timed_out;
  logic [ENTRY_W-1:0]    rdata, entry;

  assign prog_open = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign mem_we    = prog_we && prog_open;
  assign raddr     = prog_open ? '0 : step_idx + IDX_W'(1);
  // A write landing on entry 0 in the same cycle as start is forwarded so the
  // run sees the new data; other addresses leave entry 0's old contents.
  assign entry     = (mem_we && (prog_waddr == raddr)) ? prog_wdata : rdata;
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  proc_prog_mem #(
    .WIDTH(ENTRY_W),
    .DEPTH(PROG_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_waddr),
    .wdata(prog_wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Next state and next value of every registered output
  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    pending_n = pending;
    step_n    = step_idx;
    opc_n     = proc_opcode;
    addr_n    = proc_addr;
    a_n       = proc_operand_a;
    b_n       = proc_operand_b;
    last_n    = last_result;
    rv_n      = 1'b0;
    reload    = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n   = S_SETUP;
          step_n    = '0;
          pending_n = 1'b0;
          reload    = 1'b1;
        end
      end
      S_SETUP: begin
        // pending marks a SETUP that still owes the previous entry's result
        if (proc_halt) begin
          state_n = S_ERR;
        end else if (proc_ready && pending) begin
          last_n    = proc_result;
          rv_n      = 1'b1;
          pending_n = 1'b0;
          if (step_idx == IDX_W'(PROG_DEPTH - 1)) begin
            state_n = S_DONE;
          end else begin
            step_n = step_idx + IDX_W'(1);
            reload = 1'b1;
          end
        end else if (proc_ready) begin
          state_n = S_ISSUE;
        end else if (timed_out) begin
          state_n = S_ERR;
        end
      end
      S_ISSUE: begin
        if (!proc_ready) begin
          if (proc_opcode == OP_HALT) begin
            state_n = S_WAIT_HALT;
          end else begin
            state_n   = S_SETUP;
            pending_n = 1'b1;
          end
        end else if (timed_out) begin
          state_n = S_ERR;
        end
      end
      S_WAIT_HALT: begin
        if (proc_halt) state_n = S_DONE;
        else if (timed_out) state_n = S_ERR;
      end
      default: state_n = S_IDLE;
    endcase

    if (reload) begin
      opc_n  = entry[ENTRY_W-1 -: OPC_W];
      addr_n = entry[2*DATA_WIDTH +: ADDR_WIDTH];
      a_n    = entry[DATA_WIDTH +: DATA_WIDTH];
      b_n    = entry[DATA_WIDTH-1:0];
    end

    exec_n = (state_n == S_ISSUE);
    busy_n = (state_n == S_SETUP) || (state_n == S_ISSUE) || (state_n == S_WAIT_HALT);
    done_n = (state_n == S_DONE);
    terr_n = (state_n == S_ERR);
    // Loading a new entry counts as re-entering SETUP
    if (busy_n && (state_n == state) && !reload) cnt_n = cnt + CNT_W'(1);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      pending        <= 1'b0;
      step_idx       <= '0;
      proc_opcode    <= '0;
      proc_addr      <= '0;
      proc_operand_a <= '0;
      proc_operand_b <= '0;
      proc_execute   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      result_valid   <= 1'b0;
      last_result    <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      pending        <= pending_n;
      step_idx       <= step_n;
      proc_opcode    <= opc_n;
      proc_addr      <= addr_n;
      proc_operand_a <= a_n;
      proc_operand_b <= b_n;
      proc_execute   <= exec_n;
      busy           <= busy_n;
      done           <= done_n;
      timeout_err    <= terr_n;
      result_valid   <= rv_n;
      last_result    <= last_n;
    end
  end

endmodule
